// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, FSM encoding and requester indices for regfile_arbiter
package regfile_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_ARB   = 1'b1
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant selection
module rr_arb2
   import regfile_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (ptr == REQ1) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester regfile arbiter with 2-cycle response; REGFILE_ARBITER_CLEAR_EN adds the power-on clear sweep
module regfile_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_daddr,
   input  logic [2*DATA_W-1:0] req_wdata,
   input  logic [2*ADDR_W-1:0] req_aaddr,
   input  logic [2*ADDR_W-1:0] req_baddr,
   output logic [1:0]          req_ready,
   output logic                rf_write,
   output logic [ADDR_W-1:0]   rf_d_address,
   output logic [DATA_W-1:0]   rf_data_in,
   output logic [ADDR_W-1:0]   rf_a_address,
   output logic [ADDR_W-1:0]   rf_b_address,
   input  logic [DATA_W-1:0]   rf_a_data,
   input  logic [DATA_W-1:0]   rf_b_data,
   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [DATA_W-1:0]   rsp_a_data,
   output logic [DATA_W-1:0]   rsp_b_data,
   output logic                busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state, state_nxt;
   logic              ptr;
   logic [1:0]        grant;
   logic              gnt_any;
   logic              gnt_id;
   logic              s1_valid;
   logic              s1_id;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] sel_daddr, sel_aaddr, sel_baddr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_rr (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   assign gnt_any   = (state == ST_ARB) && (grant != 2'b00);
   assign gnt_id    = grant[1] ? REQ1 : REQ0;
   assign req_ready = (state == ST_ARB && !rst) ? grant : 2'b00;

   assign sel_daddr = gnt_id ? req_daddr[2*ADDR_W-1:ADDR_W] : req_daddr[ADDR_W-1:0];
   assign sel_aaddr = gnt_id ? req_aaddr[2*ADDR_W-1:ADDR_W] : req_aaddr[ADDR_W-1:0];
   assign sel_baddr = gnt_id ? req_baddr[2*ADDR_W-1:ADDR_W] : req_baddr[ADDR_W-1:0];
   assign sel_wdata = gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

`ifdef REGFILE_ARBITER_CLEAR_EN
   localparam state_t RST_STATE = ST_CLEAR;
   logic busy_q;

   always_comb begin
      state_nxt = state;
      if (state == ST_CLEAR && cnt == LAST_ADDR)
         state_nxt = ST_ARB;
   end

   // busy trails the state by one cycle so it covers the final clear write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         busy_q <= 1'b1;
      end else begin
         if (state == ST_CLEAR)
            cnt <= cnt + 1'b1;
         busy_q <= (state == ST_CLEAR);
      end
   end

   assign busy = busy_q;
`else
   localparam state_t RST_STATE = ST_ARB;

   always_comb begin
      state_nxt = state;
   end

   assign cnt  = '0;
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RST_STATE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= REQ0;
         s1_valid     <= 1'b0;
         s1_id        <= 1'b0;
         rf_write     <= 1'b0;
         rf_d_address <= '0;
         rf_data_in   <= '0;
         rf_a_address <= '0;
         rf_b_address <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_a_data   <= '0;
         rsp_b_data   <= '0;
      end else begin
         if (gnt_any)
            ptr <= ~gnt_id;
         s1_valid <= gnt_any;
         s1_id    <= gnt_id;

         if (state == ST_CLEAR) begin
            rf_write     <= 1'b1;
            rf_d_address <= cnt;
            rf_data_in   <= '0;
         end else if (gnt_any) begin
            rf_write     <= req_we[gnt_id];
            rf_d_address <= sel_daddr;
            rf_data_in   <= sel_wdata;
            rf_a_address <= sel_aaddr;
            rf_b_address <= sel_baddr;
         end else begin
            rf_write <= 1'b0;
         end

         // read data is sampled before the same cycle's write lands, giving pre-write values
         rsp_valid <= s1_valid;
         rsp_id    <= s1_id;
         if (s1_valid) begin
            rsp_a_data <= rf_a_data;
            rsp_b_data <= rf_b_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - vector table, corner sequences and randomized model check for regfile_arbiter
module tb_regfile_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid, req_we, req_ready;
   logic [15:0]   req_daddr, req_wdata, req_aaddr, req_baddr;
   logic          rf_write;
   logic [AW-1:0] rf_d_address, rf_a_address, rf_b_address;
   logic [DW-1:0] rf_data_in, rf_a_data, rf_b_data;
   logic          rsp_valid, rsp_id, busy;
   logic [DW-1:0] rsp_a_data, rsp_b_data;

   always #5 clk = ~clk;

   regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_daddr    (req_daddr),
      .req_wdata    (req_wdata),
      .req_aaddr    (req_aaddr),
      .req_baddr    (req_baddr),
      .req_ready    (req_ready),
      .rf_write     (rf_write),
      .rf_d_address (rf_d_address),
      .rf_data_in   (rf_data_in),
      .rf_a_address (rf_a_address),
      .rf_b_address (rf_b_address),
      .rf_a_data    (rf_a_data),
      .rf_b_data    (rf_b_data),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_a_data   (rsp_a_data),
      .rsp_b_data   (rsp_b_data),
      .busy         (busy)
   );

   // register file the arbiter drives: synchronous write, combinational reads
   logic [DW-1:0] mem [0:255];
   always @(posedge clk) if (rf_write) mem[rf_d_address] <= rf_data_in;
   assign rf_a_data = mem[rf_a_address];
   assign rf_b_data = mem[rf_b_address];

   typedef struct packed {
      logic       v, id, we;
      logic [7:0] d, w, a, b, ea, eb;
   } gr_t;

   typedef struct packed {
      logic [1:0]  v, we;
      logic [15:0] d, w, a, b;
      logic [1:0]  er;
   } vec_t;

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] mmem [0:255];
   int            mptr;
   gr_t           g1, g2;
   logic [1:0]    last_grant;
   logic          obs_id;
   logic [7:0]    obs_a, obs_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // one arbitration cycle: sequential-order model of grants and register file contents
   task automatic step(input logic [1:0] v, input logic [1:0] we,
                       input logic [15:0] d, input logic [15:0] w,
                       input logic [15:0] a, input logic [15:0] b);
      int         g;
      gr_t        cur;
      logic [1:0] er;
      req_valid = v; req_we = we; req_daddr = d; req_wdata = w; req_aaddr = a; req_baddr = b;
      @(negedge clk);
      g = -1;
      if (v == 2'b01)      g = 0;
      else if (v == 2'b10) g = 1;
      else if (v == 2'b11) g = mptr;
      er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      check("req_ready", req_ready, er);
      if (g1.v) begin
         check("rf_write", rf_write, g1.we);
         check("rf_d_address", rf_d_address, g1.d);
         check("rf_data_in", rf_data_in, g1.w);
         check("rf_a_address", rf_a_address, g1.a);
         check("rf_b_address", rf_b_address, g1.b);
      end else begin
         check("rf_write_idle", rf_write, 0);
      end
      check("rsp_valid", rsp_valid, g2.v);
      if (g2.v) begin
         check("rsp_id", rsp_id, g2.id);
         check("rsp_a_data", rsp_a_data, g2.ea);
         check("rsp_b_data", rsp_b_data, g2.eb);
      end
      obs_id = rsp_id; obs_a = rsp_a_data; obs_b = rsp_b_data;
      cur = '0;
      if (g >= 0) begin
         cur.v  = 1'b1;
         cur.id = g[0];
         cur.we = we[g];
         cur.d  = d[g*8 +: 8];
         cur.w  = w[g*8 +: 8];
         cur.a  = a[g*8 +: 8];
         cur.b  = b[g*8 +: 8];
         cur.ea = mmem[cur.a];
         cur.eb = mmem[cur.b];
         if (cur.we) mmem[cur.d] = cur.w;
         mptr = 1 - g;
      end
      last_grant = er;
      g2 = g1;
      g1 = cur;
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input logic exp_busy);
      rst = 1'b1;
      req_valid = 2'b11; req_we = 2'b11;
      req_daddr = 16'h0101; req_wdata = 16'hFFFF; req_aaddr = 16'h0202; req_baddr = 16'h0303;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rf_write", rf_write, 0);
      check("rst_rf_addrs", {rf_d_address, rf_a_address, rf_b_address}, 0);
      check("rst_rf_data_in", rf_data_in, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", {rsp_a_data, rsp_b_data}, 0);
      check("rst_busy", busy, exp_busy);
      @(posedge clk); @(posedge clk); #1;
      req_valid = 2'b00; req_we = 2'b00;
      rst = 1'b0;
      mptr = 0; g1 = '0; g2 = '0; last_grant = 2'b00;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [10];
      logic [1:0] rv, rwe;
      logic [15:0] rd, rw, ra, rb;
      logic       clr;

      tbl[0] = '{v:2'b11, we:2'b01, d:16'h0010, w:16'h005A, a:16'h1000, b:16'h2001, er:2'b01};
      tbl[1] = '{v:2'b11, we:2'b00, d:16'h0000, w:16'h0000, a:16'h1020, b:16'h2010, er:2'b10};
      tbl[2] = '{v:2'b11, we:2'b00, d:16'h0000, w:16'h0000, a:16'h1020, b:16'h2010, er:2'b01};
      tbl[3] = '{v:2'b11, we:2'b10, d:16'h3000, w:16'h7700, a:16'h3020, b:16'h1010, er:2'b10};
      tbl[4] = '{v:2'b01, we:2'b00, d:16'h0000, w:16'h0000, a:16'h0030, b:16'h0010, er:2'b01};
      tbl[5] = '{v:2'b10, we:2'b00, d:16'h0000, w:16'h0000, a:16'h1000, b:16'h3000, er:2'b10};
      tbl[6] = '{v:2'b10, we:2'b00, d:16'h0000, w:16'h0000, a:16'h1000, b:16'h3000, er:2'b10};
      tbl[7] = '{v:2'b10, we:2'b00, d:16'h0000, w:16'h0000, a:16'h1000, b:16'h3000, er:2'b10};
      tbl[8] = '{v:2'b10, we:2'b00, d:16'h0000, w:16'h0000, a:16'h1000, b:16'h3000, er:2'b10};
      tbl[9] = '{v:2'b00, we:2'b00, d:16'h0000, w:16'h0000, a:16'h0000, b:16'h0000, er:2'b00};

      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'($urandom_range(0, 255));
         mmem[i] = mem[i];
      end

`ifdef REGFILE_ARBITER_CLEAR_EN
      clr = 1'b1;
`else
      clr = 1'b0;
`endif
      do_reset(clr);

`ifdef REGFILE_ARBITER_CLEAR_EN
      // abort the sweep at address 0x80, then let it run to completion
      req_valid = 2'b11;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         check("clr_first_idle", rf_write, 0);
         check("clr_busy0", busy, 1);
         for (int k = 1; k <= ((pass == 0) ? 129 : 257); k++) begin
            @(negedge clk);
            if (k <= 256) begin
               check("clr_write", rf_write, 1);
               check("clr_addr", rf_d_address, k - 1);
               check("clr_data", rf_data_in, 0);
               check("clr_busy", busy, 1);
            end else begin
               check("clr_done_write", rf_write, 0);
               check("clr_done_busy", busy, 0);
            end
            if (k <= 255) check("clr_ready", req_ready, 0);
            if (k == 255) req_valid = 2'b00;
         end
         if (pass == 0) begin
            do_reset(1'b1);
            req_valid = 2'b11;
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) mmem[i] = '0;
`endif

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].we, tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].b);
         check("tbl_ready", last_grant, tbl[i].er);
         if (i == 3) begin
            check("wr_then_rd_id", obs_id, 1);
            check("wr_then_rd_data", obs_a, 8'h5A);
         end
      end

      // same-address read-modify-write returns the old value, next read the new one
      step(2'b01, 2'b01, 16'h0020, 16'h0011, 16'h0000, 16'h0000);
      step(2'b01, 2'b01, 16'h0020, 16'h0022, 16'h0020, 16'h0020);
      step(2'b01, 2'b00, 16'h0000, 16'h0000, 16'h0020, 16'h0000);
      step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("rmw_old_a", obs_a, 8'h11);
      check("rmw_old_b", obs_b, 8'h11);
      step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("rmw_new_a", obs_a, 8'h22);

      // reset with reads in flight: responses dropped, pointer back to requester 0
      step(2'b11, 2'b00, 16'h0000, 16'h0000, 16'h0102, 16'h0304);
      step(2'b11, 2'b00, 16'h0000, 16'h0000, 16'h0506, 16'h0708);
      do_reset(clr);
`ifdef REGFILE_ARBITER_CLEAR_EN
      for (int k = 0; k < 258; k++) @(posedge clk);
      #1;
      check("reclear_busy", busy, 0);
      for (int i = 0; i < 256; i++) mmem[i] = '0;
`endif
      step(2'b11, 2'b00, 16'h0000, 16'h0000, 16'h0011, 16'h0022);
      step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

      // randomized traffic; each request is held until the model grants it
      rv = 2'b00; rwe = 2'b00; rd = '0; rw = '0; ra = '0; rb = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!rv[i] || last_grant[i]) begin
               rv[i]         = ($urandom_range(0, 3) != 0);
               rwe[i]        = 1'($urandom_range(0, 1));
               rd[i*8 +: 8]  = 8'($urandom_range(0, 7));
               rw[i*8 +: 8]  = 8'($urandom_range(0, 255));
               ra[i*8 +: 8]  = 8'($urandom_range(0, 7));
               rb[i*8 +: 8]  = 8'($urandom_range(0, 7));
            end
         end
         step(rv, rwe, rd, rw, ra, rb);
      end
      for (int c = 0; c < 3; c++) step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning register-file address width (depth = 2**ADDR_W).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning register-file data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be, in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  async active-high reset.
- req_valid  in  2  per-requester request; held until granted.
- req_we  in  2  per-requester write enable.
- req_daddr  in  2*ADDR_W  write addresses; requester 0 in the low slice.
- req_wdata  in  2*DATA_W  write data.
- req_aaddr  in  2*ADDR_W  read port A addresses.
- req_baddr  in  2*ADDR_W  read port B addresses.
- req_ready  out  2  one-hot grant, same cycle as the accepted request.
- rf_write  out  1  regfile write strobe.
- rf_d_address  out  ADDR_W  regfile write address.
- rf_data_in  out  DATA_W  regfile write data.
- rf_a_address  out  ADDR_W  regfile read address A.
- rf_b_address  out  ADDR_W  regfile read address B.
- rf_a_data  in  DATA_W  regfile combinational read data A.
- rf_b_data  in  DATA_W  regfile combinational read data B.
- rsp_valid  out  1  response strobe.
- rsp_id  out  1  requester index of the response.
- rsp_a_data  out  DATA_W  captured A data.
- rsp_b_data  out  DATA_W  captured B data.
- busy  out  1  high while the clear sequence runs.

Function
REQ-005 The FSM SHALL have states CLEAR and ARB, with CLEAR -> ARB when the clear counter reaches 2**ADDR_W-1.
REQ-006 In ARB, at most one requester SHALL be granted per cycle: a lone valid requester is always granted; when both are valid, the requester selected by the round-robin pointer is granted.
REQ-007 The round-robin pointer SHALL point to the non-granted requester after every grant and SHALL hold when there is no grant.
REQ-008 req_ready SHALL be combinational from req_valid, the state and the pointer, and SHALL be 0 in CLEAR.
REQ-009 All rf_* outputs SHALL be registered: a grant in cycle N drives the granted requester's addresses, data and rf_write=req_we in cycle N+1.
REQ-010 rf_write SHALL be 0 in any cycle following a non-grant cycle in ARB.
REQ-011 Read data SHALL be sampled from rf_a_data/rf_b_data at the end of cycle N+1; rsp_valid, rsp_id and rsp_*_data SHALL assert in cycle N+2, giving a fixed latency of 2 for every grant, including write grants.
REQ-012 On a grant that reads and writes the same address, the response SHALL return the pre-write value; a later grant SHALL see the new value.
REQ-013 Back-to-back grants SHALL be accepted every cycle with no bubbles.
REQ-014 In CLEAR, rf_write SHALL be 1, rf_data_in SHALL be 0 and rf_d_address SHALL equal the counter, which increments 0..2**ADDR_W-1 once per cycle, one address per cycle.

Reset
REQ-015 On rst, all outputs SHALL be 0 except busy; the pointer SHALL be 0, the counter SHALL be 0, and the state SHALL be CLEAR (or ARB when the clear feature is compiled out).
REQ-016 Reset asserted mid-clear or mid-transaction SHALL abort immediately; in-flight responses SHALL be dropped and clear SHALL restart at address 0.

Configuration
REQ-017 With macro REGFILE_ARBITER_CLEAR_EN defined, the CLEAR state, the counter and busy SHALL be implemented, and busy SHALL be 1 from reset until the cycle after the last clear write.
REQ-018 Without REGFILE_ARBITER_CLEAR_EN, the FSM SHALL reset into ARB, busy SHALL be tied to 0, and no clear writes SHALL occur.

Structure
REQ-019 A shared package regfile_pkg SHALL hold the ADDR_W/DATA_W defaults, the FSM state encoding, and the requester index constants.
REQ-020 The two-way round-robin selection SHALL be a sub-module rr_arb2, with inputs valid[1:0] and ptr and output grant[1:0].

Verification
REQ-021 Clear: release rst with CLEAR_EN -> busy=1 for 256 cycles, rf_write=1 with addresses 0..255 and data 0, then busy=0 and req_ready enabled.
REQ-022 Contention: both valid continuously with pointer 0 -> grants alternate 0,1,0,1 and rsp_id follows the same order two cycles later.
REQ-023 Write then read: req0 writes 0x5A to address 0x10, then req1 reads A=0x10 -> rsp_a_data=0x5A with rsp_id=1.
REQ-024 Same-address RMW: address 0x20 holds 0x11; one grant writes 0x22 and reads A=0x20 -> response 0x11; next read -> 0x22.
REQ-025 Reset mid-clear: assert rst at clear address 0x80 -> outputs zero; after release, clear restarts at 0x00.
REQ-026 Lone requester: only req1 valid for 4 cycles with pointer=1 or 0 -> req_ready=2'b10 every cycle with no stall.
